// File: rtl/multi_bus_arbiter.sv
// multi_bus_arbiter: N-way arbiter serialising a latched {data,addr} frame onto a beat bus
module multi_bus_arbiter #(
  parameter int NREQ  = 4,
  parameter int ADDRW = 24,
  parameter int BEATW = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        prio_mode,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ*(ADDRW+8)-1:0]   req_data,
  input  logic                        bus_ready,
  output logic [BEATW-1:0]            data_out,
  output logic                        valid_out,
  output logic [NREQ-1:0]             grant,
  output logic [NREQ-1:0]             done
);
  localparam int FRAMEW = ADDRW + 8;
  localparam int NBEATS = FRAMEW / BEATW;
  localparam int PW     = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CW     = NBEATS > 1 ? $clog2(NBEATS) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t              r_state, w_state_nxt;
  logic [NREQ-1:0]     r_grant;
  logic [FRAMEW-1:0]   r_shift;
  logic [CW-1:0]       r_cnt;
  logic [PW-1:0]       r_ptr;

  logic                w_xfer, w_last, w_arb, w_take, w_found;
  logic [NREQ-1:0]     w_cand, w_win_oh;
  logic [PW-1:0]       w_idx, w_ptr_nxt;
  logic [FRAMEW-1:0]   w_frame;

  assign w_xfer    = (r_state == SEND) && bus_ready;
  assign w_last    = w_xfer && (r_cnt == CW'(NBEATS - 1));
  assign w_cand    = (r_state == IDLE) ? req : (req & ~r_grant);
  assign w_arb     = (r_state == IDLE) || w_last;
  assign w_take    = w_arb && w_found;
  assign w_win_oh  = NREQ'(1) << w_idx;
  assign w_ptr_nxt = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;

  assign valid_out = (r_state == SEND);
  assign data_out  = valid_out ? r_shift[BEATW-1:0] : '0;
  assign grant     = r_grant;
  assign done      = w_last ? r_grant : '0;

  // Winner search: from index 0 in fixed mode, from the RR pointer (wrapping) otherwise
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      automatic int j;
      j = (prio_mode ? 0 : int'(r_ptr)) + k;
      if (j >= NREQ) j = j - NREQ;
      if (w_cand[PW'(j)]) begin
        w_found = 1'b1;
        w_idx   = PW'(j);
      end
    end
  end

  // Frame mux for the selected winner
  always_comb begin
    w_frame = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_idx == PW'(i)) w_frame = req_data[i*FRAMEW +: FRAMEW];
  end

  // Next state: arbitration points decide between SEND and IDLE
  always_comb begin
    w_state_nxt = w_arb ? (w_found ? SEND : IDLE) : r_state;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Grant, frame shift register, beat counter and RR pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant <= '0;
      r_shift <= '0;
      r_cnt   <= '0;
      r_ptr   <= '0;
    end else if (w_take) begin
      r_grant <= w_win_oh;
      r_shift <= w_frame;
      r_cnt   <= '0;
      r_ptr   <= w_ptr_nxt;
    end else if (w_last) begin
      r_grant <= '0;
      r_cnt   <= '0;
    end else if (w_xfer) begin
      r_cnt   <= r_cnt + 1'b1;
      r_shift <= r_shift >> BEATW;
    end
  end
endmodule

// File: tb/tb_multi_bus_arbiter.sv
// tb_multi_bus_arbiter: directed checks of arbitration, serialisation and reset
module tb_multi_bus_arbiter;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         prio_mode = 1'b0;
  logic         bus_ready = 1'b1;
  logic [3:0]   req = 4'b0000;
  logic [127:0] req_data;
  logic [7:0]   data_out;
  logic         valid_out;
  logic [3:0]   grant, done;
  logic [31:0]  fr [4] = '{32'h10203040, 32'hA1B2C3D4, 32'h55667788, 32'h99AABBCC};
  int           ncmp = 0;
  int           nerr = 0;
  int           o4 [5] = '{0, 1, 2, 3, 0};
  int           o5 [4] = '{1, 3, 1, 3};

  assign req_data = {fr[3], fr[2], fr[1], fr[0]};

  always #5 clk = ~clk;

  multi_bus_arbiter #(.NREQ(4), .ADDRW(24), .BEATW(8)) dut (
    .clk(clk), .rst(rst), .prio_mode(prio_mode), .req(req), .req_data(req_data),
    .bus_ready(bus_ready), .data_out(data_out), .valid_out(valid_out),
    .grant(grant), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_grant"}, grant, 4'b0000);
    chk({tag, "_valid"}, valid_out, 1'b0);
    chk({tag, "_data"}, data_out, 8'h00);
    chk({tag, "_done"}, done, 4'b0000);
  endtask

  initial begin
    #2;
    chk_idle("rst_init");
    cyc();
    rst = 1'b0;
    #1;
    chk_idle("post_rst");
    // single frame from requester 1
    req = 4'b0010;
    #1;
    chk("t2_pre_grant", grant, 4'b0000);
    cyc();
    req = 4'b0000;
    #1;
    chk("t2_grant", grant, 4'b0010);
    chk("t2_valid", valid_out, 1'b1);
    chk("t2_b0", data_out, 8'hD4);
    chk("t2_done0", done, 4'b0000);
    cyc(); #1;
    chk("t2_b1", data_out, 8'hC3);
    cyc(); #1;
    chk("t2_b2", data_out, 8'hB2);
    chk("t2_done2", done, 4'b0000);
    cyc(); #1;
    chk("t2_b3", data_out, 8'hA1);
    chk("t2_done3", done, 4'b0010);
    cyc(); #1;
    chk_idle("t2_end");
    // backpressure on beat C3
    req = 4'b0010;
    cyc();
    req = 4'b0000;
    #1;
    chk("t3_b0", data_out, 8'hD4);
    chk("t3_grant", grant, 4'b0010);
    cyc();
    bus_ready = 1'b0;
    #1;
    chk("t3_hold1", data_out, 8'hC3);
    chk("t3_hold1_v", valid_out, 1'b1);
    cyc(); #1;
    chk("t3_hold2", data_out, 8'hC3);
    cyc(); #1;
    chk("t3_hold3", data_out, 8'hC3);
    chk("t3_hold3_v", valid_out, 1'b1);
    cyc();
    bus_ready = 1'b1;
    #1;
    chk("t3_hold4", data_out, 8'hC3);
    cyc(); #1;
    chk("t3_b2", data_out, 8'hB2);
    cyc(); #1;
    chk("t3_b3", data_out, 8'hA1);
    chk("t3_done", done, 4'b0010);
    cyc(); #1;
    chk_idle("t3_end");
    // asynchronous reset mid-frame
    req = 4'b0100;
    cyc();
    req = 4'b0000;
    #1;
    chk("t1_grant", grant, 4'b0100);
    chk("t1_b0", data_out, 8'h88);
    cyc(); #1;
    chk("t1_b1", data_out, 8'h77);
    rst = 1'b1;
    #1;
    chk_idle("t1_async");
    cyc();
    rst = 1'b0;
    // round-robin, all requesting
    prio_mode = 1'b0;
    req = 4'b1111;
    cyc();
    for (int f = 0; f < 5; f++)
      for (int b = 0; b < 4; b++) begin
        #1;
        chk("t4_grant", grant, 4'b0001 << o4[f]);
        chk("t4_data", data_out, 8'(fr[o4[f]] >> (8 * b)));
        chk("t4_done", done, (b == 3) ? (4'b0001 << o4[f]) : 4'b0000);
        cyc();
      end
    req = 4'b0000;
    #1;
    chk("t4_tail_grant", grant, 4'b0010);
    cyc(); cyc(); cyc(); cyc(); #1;
    chk_idle("t4_end");
    // fixed priority, owner masked at handover
    prio_mode = 1'b1;
    req = 4'b1010;
    cyc();
    for (int f = 0; f < 4; f++)
      for (int b = 0; b < 4; b++) begin
        #1;
        chk("t5_grant", grant, 4'b0001 << o5[f]);
        chk("t5_data", data_out, 8'(fr[o5[f]] >> (8 * b)));
        chk("t5_done", done, (b == 3) ? (4'b0001 << o5[f]) : 4'b0000);
        cyc();
      end
    req = 4'b0000;
    cyc(); cyc(); cyc(); cyc(); #1;
    chk_idle("t5_end");
    // frame latched against req_data changes; reset then restart
    prio_mode = 1'b0;
    req = 4'b0010;
    cyc(); #1;
    chk("t6_grant", grant, 4'b0010);
    chk("t6_b0", data_out, 8'hD4);
    fr[1] = 32'hFFFFFFFF;
    cyc(); #1;
    chk("t6_b1", data_out, 8'hC3);
    cyc(); #1;
    chk("t6_b2", data_out, 8'hB2);
    cyc(); #1;
    chk("t6_b3", data_out, 8'hA1);
    chk("t6_done", done, 4'b0010);
    fr[1] = 32'hA1B2C3D4;
    cyc(); #1;
    chk("t6_gap_grant", grant, 4'b0000);
    chk("t6_gap_valid", valid_out, 1'b0);
    cyc(); #1;
    chk("t6_regrant", grant, 4'b0010);
    chk("t6_r_b0", data_out, 8'hD4);
    cyc(); #1;
    chk("t6_r_b1", data_out, 8'hC3);
    cyc(); #1;
    chk("t6_r_b2", data_out, 8'hB2);
    rst = 1'b1;
    #1;
    chk_idle("t6_rst");
    cyc();
    rst = 1'b0;
    cyc(); #1;
    chk("t6_restart_grant", grant, 4'b0010);
    chk("t6_restart_valid", valid_out, 1'b1);
    chk("t6_restart_b0", data_out, 8'hD4);
    req = 4'b0000;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
